// File: rtl/r30_entropy_gen.sv
// Rule 30 cellular-automaton entropy source on an N-cell ring: combinational seed step plus clocked state register.
// Optional center-column word collector enabled by defining R30_CENTER_WORD_EN.
module r30_entropy_gen #(
  parameter int N      = 128,
  parameter int CENTER = N / 2,
  parameter int OUT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] seed,
  output logic [N-1:0] next_seed,
  input  logic         load,
  input  logic         step,
  output logic [N-1:0] state,
  output logic         rand_bit,
`ifdef R30_CENTER_WORD_EN
  output logic [OUT_W-1:0] word,
  output logic             word_valid,
`endif
  output logic         valid
);

  localparam logic [N-1:0] DS = {{(N-1){1'b0}}, 1'b1} << CENTER;

  // Bit i+1 is the left (MSB-side) neighbour, bit i-1 the right one; both wrap.
  function automatic logic [N-1:0] rule30(input logic [N-1:0] v);
    logic [N-1:0] r;
    int unsigned  lft;
    int unsigned  rgt;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lft  = (i == N - 1) ? 0 : i + 1;
      rgt  = (i == 0) ? N - 1 : i - 1;
      r[i] = v[lft] ^ (v[i] | v[rgt]);
    end
    return r;
  endfunction

  logic [N-1:0] stepped;
  logic [N-1:0] stepped_safe;
  logic [N-1:0] loaded_safe;

  always_comb begin
    next_seed    = rule30(seed);
    stepped      = rule30(state);
    // All-zero is a fixed point of the rule, so it is replaced by the default seed.
    stepped_safe = (stepped == '0) ? DS : stepped;
    loaded_safe  = (seed == '0) ? DS : seed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DS;
      valid <= 1'b0;
    end else if (load) begin
      state <= loaded_safe;
      valid <= 1'b0;
    end else if (step) begin
      state <= stepped_safe;
      valid <= 1'b1;
    end
  end

  assign rand_bit = state[CENTER];

`ifdef R30_CENTER_WORD_EN
  localparam int CW = $clog2(OUT_W + 1);
  logic [CW-1:0] word_cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      word       <= '0;
      word_cnt   <= '0;
      word_valid <= 1'b0;
    end else if (step) begin
      word <= {word[OUT_W-2:0], stepped_safe[CENTER]};
      if (word_cnt == CW'(OUT_W - 1)) begin
        word_cnt   <= '0;
        word_valid <= 1'b1;
      end else begin
        word_cnt   <= word_cnt + 1'b1;
        word_valid <= 1'b0;
      end
    end else begin
      word_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_r30_entropy_gen.sv
// Self-checking bench for r30_entropy_gen: directed steps, reference model feeding an expected-value queue.
// Exercises the word collector too when R30_CENTER_WORD_EN is defined.
module tb_r30_entropy_gen;

  localparam int N      = 128;
  localparam int CENTER = 64;
  localparam int OUT_W  = 8;
  localparam logic [N-1:0] DS = {{(N-1){1'b0}}, 1'b1} << CENTER;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         step = 1'b0;
  logic [N-1:0] seed = '0;
  logic [N-1:0] next_seed;
  logic [N-1:0] state;
  logic         rand_bit;
  logic         valid;
`ifdef R30_CENTER_WORD_EN
  logic [OUT_W-1:0] word;
  logic             word_valid;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  r30_entropy_gen #(.N(N), .CENTER(CENTER), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .seed(seed), .next_seed(next_seed),
    .load(load), .step(step), .state(state), .rand_bit(rand_bit),
`ifdef R30_CENTER_WORD_EN
    .word(word), .word_valid(word_valid),
`endif
    .valid(valid)
  );

  always #5 if (clk_en) clk = ~clk; else clk = 1'b0;

  typedef struct {
    logic [N-1:0]     st;
    logic             vl;
    logic [OUT_W-1:0] wd;
    logic             wv;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [N-1:0]     m_state;
  logic             m_valid;
  logic [OUT_W-1:0] m_word;
  int               m_cnt;
  logic             m_wv;

  // Rotation-based form of the rule: left neighbour = rotate right, right neighbour = rotate left.
  function automatic logic [N-1:0] ref_rule(input logic [N-1:0] v);
    logic [N-1:0] lft;
    logic [N-1:0] rgt;
    lft = {v[0], v[N-1:1]};
    rgt = {v[N-2:0], v[N-1]};
    return lft ^ (v | rgt);
  endfunction

  function automatic logic [N-1:0] onehot(input int b);
    logic [N-1:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  task automatic chk_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic expv);
    n_checks++;
    assert (got === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, expv);
    end
  endtask

  // Drive one clock with the given controls; model result is queued, then compared after the edge.
  task automatic cyc(input logic r, input logic l, input logic s, input logic [N-1:0] sd);
    logic [N-1:0] t;
    exp_t e;
    rst = r; load = l; step = s; seed = sd;
    if (r) begin
      m_state = DS; m_valid = 1'b0; m_word = '0; m_cnt = 0; m_wv = 1'b0;
    end else if (l) begin
      m_state = (sd == '0) ? DS : sd;
      m_valid = 1'b0; m_word = '0; m_cnt = 0; m_wv = 1'b0;
    end else if (s) begin
      t = ref_rule(m_state);
      if (t == '0) t = DS;
      m_state = t;
      m_valid = 1'b1;
      m_word  = {m_word[OUT_W-2:0], t[CENTER]};
      m_cnt++;
      m_wv = (m_cnt == OUT_W);
      if (m_cnt == OUT_W) m_cnt = 0;
    end else begin
      m_wv = 1'b0;
    end
    e.st = m_state; e.vl = m_valid; e.wd = m_word; e.wv = m_wv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_vec("state", state, e.st);
    chk_bit("valid", valid, e.vl);
    chk_bit("rand_bit", rand_bit, e.st[CENTER]);
`ifdef R30_CENTER_WORD_EN
    chk_vec("word", N'(word), N'(e.wd));
    chk_bit("word_valid", word_valid, e.wv);
`endif
    rst = 1'b0; load = 1'b0; step = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rs;
    m_state = DS; m_valid = 1'b0; m_word = '0; m_cnt = 0; m_wv = 1'b0;

    // Combinational step with the clock stopped.
    seed = onehot(64); #1;
    chk_vec("comb_center", next_seed, onehot(63) | onehot(64) | onehot(65));
    seed = onehot(0); #1;
    chk_vec("comb_wrap_lo", next_seed, onehot(127) | onehot(0) | onehot(1));
    seed = onehot(127); #1;
    chk_vec("comb_wrap_hi", next_seed, onehot(126) | onehot(127) | onehot(0));
    for (int k = 0; k < 4; k++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      seed = rs; #1;
      chk_vec("comb_rand", next_seed, ref_rule(rs));
    end

    clk_en = 1'b1;
    #2;
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    chk_vec("reset_ds", state, DS);
    chk_bit("reset_valid", valid, 1'b0);

    cyc(0, 0, 1, '0);
    chk_vec("step1_bits", N'(state[65:63]), N'(3'b111));
    chk_bit("step1_rand", rand_bit, 1'b1);
    chk_bit("step1_valid", valid, 1'b1);
    cyc(0, 0, 1, '0);
    chk_vec("step2_bits", N'(state[66:62]), N'(5'b11001));

    cyc(0, 0, 0, '0);                 // hold
    cyc(0, 1, 0, '0);                 // zero seed -> DS
    chk_vec("load_zero", state, DS);
    cyc(0, 1, 0, '1);
    cyc(0, 0, 1, '0);                 // all-ones step -> lockout
    chk_vec("lockout", state, DS);
    chk_bit("lockout_valid", valid, 1'b1);
    rs = {$urandom, $urandom, $urandom, $urandom} | onehot(3);
    cyc(0, 1, 1, rs);
    chk_vec("load_over_step", state, rs);
    cyc(0, 0, 1, '0);
    cyc(1, 1, 1, rs);
    chk_vec("rst_priority", state, DS);
    chk_bit("rst_priority_valid", valid, 1'b0);

    // Word collection from reset plus mixed random traffic.
    for (int k = 0; k < 10; k++) cyc(0, 0, 1, '0);
    cyc(1, 0, 0, '0);
    for (int k = 0; k < 40; k++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 3) != 0), rs);
    end
    cyc(0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
